// File: rtl/multi_channel_depth_fifo_pkg.sv
// Shared project constants for the multi-channel depth FIFO.
// Latency: n/a (constants only).
// Backpressure: n/a.
package multi_channel_depth_fifo_pkg;

  localparam int MCF_C_LOG      = 5;     // 32 channels
  localparam int MCF_FIFO_WIDTH = 1024;  // data word width
  localparam int MCF_D_LOG      = 2;     // 4 entries per channel
  localparam int MCF_RDY_SLACK  = 1;     // free entries needed for rdy

endpackage

// File: rtl/multi_channel_depth_fifo_chan_ctrl.sv
// Per-channel bookkeeping: pointers, occupancy, emp/rdy flags, error pulses.
// Latency: pointer/count updates land on the next rising edge; flags decode registered count.
// Backpressure: enq to a full channel is refused unless the same cycle pops it; deq to empty is refused.
//
// Ports: clk/rst_n clock and async active-low reset; arm gates all acceptance;
// enq_hit/deq_hit are requests already decoded to this channel; wptr/rptr/count
// are the registered state; wr_acc tells the top to write the array; ovf_pls and
// udf_pls flag refused requests for the sticky error bits.
module mcfifo_chan_ctrl
  import multi_channel_depth_fifo_pkg::*;
#(
  parameter int D_LOG     = MCF_D_LOG,
  parameter int RDY_SLACK = MCF_RDY_SLACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             enq_hit,
  input  logic             deq_hit,
  output logic [D_LOG-1:0] wptr,
  output logic [D_LOG-1:0] rptr,
  output logic [D_LOG:0]   count,
  output logic             emp,
  output logic             rdy,
  output logic             wr_acc,
  output logic             ovf_pls,
  output logic             udf_pls
);

  localparam int D = 1 << D_LOG;

  logic full;
  logic rd_acc;

  always_comb begin
    full    = (count == (D_LOG+1)'(D));
    emp     = (count == '0);
    rdy     = (((D_LOG+1)'(D) - count) >= (D_LOG+1)'(RDY_SLACK));
    rd_acc  = arm & deq_hit & ~emp;
    // A pop in the same cycle frees the slot, so a full channel can still take a write.
    wr_acc  = arm & enq_hit & (~full | rd_acc);
    ovf_pls = arm & enq_hit & full & ~rd_acc;
    // Empty channel with a simultaneous write still underflows: there is no bypass.
    udf_pls = arm & deq_hit & emp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multi_channel_depth_fifo.sv
// Bank of C independent show-ahead FIFOs sharing one storage array.
// Latency: write visible at dot one cycle after acceptance; dot/cnt are combinational on deq_idx.
// Backpressure: rdy[c] advertises free space; refused requests leave state alone and set ovf/udf.
//
// Ports: CLK, RST (async active-low); enq/enq_idx/din write side;
// deq/deq_idx read side with dot (head word) and cnt (occupancy) of deq_idx;
// emp/rdy per-channel status vectors; ovf/udf sticky error flags.
module multi_channel_depth_fifo
  import multi_channel_depth_fifo_pkg::*;
#(
  parameter int C_LOG      = MCF_C_LOG,
  parameter int FIFO_WIDTH = MCF_FIFO_WIDTH,
  parameter int D_LOG      = MCF_D_LOG,
  parameter int RDY_SLACK  = MCF_RDY_SLACK
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    enq,
  input  logic [C_LOG-1:0]        enq_idx,
  input  logic                    deq,
  input  logic [C_LOG-1:0]        deq_idx,
  input  logic [FIFO_WIDTH-1:0]   din,
  output logic [FIFO_WIDTH-1:0]   dot,
  output logic [(1<<C_LOG)-1:0]   emp,
  output logic [(1<<C_LOG)-1:0]   rdy,
  output logic [D_LOG:0]          cnt,
  output logic                    ovf,
  output logic                    udf
);

  localparam int C = 1 << C_LOG;
  localparam int D = 1 << D_LOG;

  logic                  armed;
  logic [D_LOG-1:0]      wptr [C];
  logic [D_LOG-1:0]      rptr [C];
  logic [D_LOG:0]        count [C];
  logic [C-1:0]          wr_acc;
  logic [C-1:0]          ovf_pls;
  logic [C-1:0]          udf_pls;
  logic [FIFO_WIDTH-1:0] mem [C*D];

  // Holds off acceptance for the first edge after reset release, so a request
  // sitting on the bus as RST rises is never taken.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  for (genvar g = 0; g < C; g++) begin : g_chan
    mcfifo_chan_ctrl #(
      .D_LOG     (D_LOG),
      .RDY_SLACK (RDY_SLACK)
    ) u_chan (
      .clk     (CLK),
      .rst_n   (RST),
      .arm     (armed),
      .enq_hit (enq && (enq_idx == C_LOG'(g))),
      .deq_hit (deq && (deq_idx == C_LOG'(g))),
      .wptr    (wptr[g]),
      .rptr    (rptr[g]),
      .count   (count[g]),
      .emp     (emp[g]),
      .rdy     (rdy[g]),
      .wr_acc  (wr_acc[g]),
      .ovf_pls (ovf_pls[g]),
      .udf_pls (udf_pls[g])
    );
  end

  // Storage is deliberately not reset; only enq_idx's channel can raise wr_acc.
  always_ff @(posedge CLK) begin
    if (|wr_acc) mem[{enq_idx, wptr[enq_idx]}] <= din;
  end

  assign dot = mem[{deq_idx, rptr[deq_idx]}];
  assign cnt = count[deq_idx];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf | (|ovf_pls);
      udf <= udf | (|udf_pls);
    end
  end

endmodule

// File: tb/tb_multi_channel_depth_fifo.sv
module tb_multi_channel_depth_fifo;

  localparam int CL = 5;
  localparam int W  = 1024;
  localparam int DL = 2;
  localparam int C  = 1 << CL;
  localparam int D  = 1 << DL;

  logic          CLK = 1'b0;
  logic          RST;
  logic          enq, deq;
  logic [CL-1:0] enq_idx, deq_idx;
  logic [W-1:0]  din, dot;
  logic [C-1:0]  emp, rdy;
  logic [DL:0]   cnt;
  logic          ovf, udf;

  always #5 CLK = ~CLK;

  multi_channel_depth_fifo dut (
    .CLK(CLK), .RST(RST), .enq(enq), .enq_idx(enq_idx), .deq(deq), .deq_idx(deq_idx),
    .din(din), .dot(dot), .emp(emp), .rdy(rdy), .cnt(cnt), .ovf(ovf), .udf(udf)
  );

  int total = 0;
  int bad   = 0;

  // Reference: one queue per channel plus the two sticky flags.
  logic [W-1:0] mq [C][$];
  bit m_ovf, m_udf;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got[63:0], exp[63:0]);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < C; c++) mq[c].delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [C-1:0] e_emp, e_rdy;
    int sz;
    for (int c = 0; c < C; c++) begin
      e_emp[c] = (mq[c].size() == 0);
      e_rdy[c] = ((D - mq[c].size()) >= 1);
    end
    sz = mq[deq_idx].size();
    chk({tag, ".emp"}, W'(emp), W'(e_emp));
    chk({tag, ".rdy"}, W'(rdy), W'(e_rdy));
    chk({tag, ".cnt"}, W'(cnt), W'(sz));
    chk({tag, ".ovf"}, W'(ovf), W'(m_ovf));
    chk({tag, ".udf"}, W'(udf), W'(m_udf));
    if (sz != 0) chk({tag, ".dot"}, dot, mq[deq_idx][0]);
  endtask

  task automatic model_step(input bit e, input int ei, input bit d, input int di, input logic [W-1:0] data);
    int se, sd;
    bit ad, ae;
    se = mq[ei].size();
    sd = mq[di].size();
    ad = d && (sd > 0);
    ae = e && ((se < D) || (ad && ei == di));
    if (d && sd == 0) m_udf = 1'b1;
    if (e && !ae)     m_ovf = 1'b1;
    if (ad) void'(mq[di].pop_front());
    if (ae) mq[ei].push_back(data);
  endtask

  // Called at a falling edge: drive, check pre-edge outputs, advance model, cross the edge.
  task automatic step(input bit e, input int ei, input bit d, input int di, input logic [W-1:0] data);
    enq = e; enq_idx = CL'(ei); deq = d; deq_idx = CL'(di); din = data;
    #1 check_outputs("step");
    model_step(e, ei, d, di, data);
    @(posedge CLK);
    @(negedge CLK);
    enq = 1'b0; deq = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0; enq = 1'b0; deq = 1'b0;
    model_clear();
    #1 check_outputs("rst");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; enq = 1'b0; deq = 1'b0; enq_idx = '0; deq_idx = '0; din = '0;
    model_clear();
    #1 check_outputs("reset");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Fill ch3, then check full-state flags and head.
    step(1, 3, 0, 3, W'('hA));
    step(1, 3, 0, 3, W'('hB));
    step(1, 3, 0, 3, W'('hC));
    step(1, 3, 0, 3, W'('hD));
    deq_idx = CL'(3);
    #1;
    chk("full.cnt", W'(cnt), W'(4));
    chk("full.emp3", W'(emp[3]), W'(0));
    chk("full.rdy3", W'(rdy[3]), W'(0));
    chk("full.dot", dot, W'('hA));

    // Overflow: 5th write dropped.
    @(negedge CLK);
    step(1, 3, 0, 3, W'('hE));
    #1;
    chk("ovf.flag", W'(ovf), W'(1));
    chk("ovf.cnt", W'(cnt), W'(4));
    chk("ovf.head", dot, W'('hA));

    // Drain ch3 in order.
    @(negedge CLK);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 3, '0);
    deq_idx = CL'(3);
    #1 chk("drain.emp3", W'(emp[3]), W'(1));

    // Same-cycle enq+deq on empty ch0: write only, underflow.
    @(negedge CLK);
    step(1, 0, 1, 0, W'('h5));
    deq_idx = CL'(0);
    #1;
    chk("samemp.udf", W'(udf), W'(1));
    chk("samemp.cnt", W'(cnt), W'(1));
    chk("samemp.dot", dot, W'('h5));

    // Same-cycle enq+deq on full ch7 after a clean reset.
    @(negedge CLK);
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 7, 0, 7, W'(i));
    step(1, 7, 1, 7, W'('h9));
    deq_idx = CL'(7);
    #1;
    chk("samefull.cnt", W'(cnt), W'(4));
    chk("samefull.ovf", W'(ovf), W'(0));
    @(negedge CLK);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 7, '0);
    deq_idx = CL'(7);
    #1 chk("samefull.nine", dot, W'('h9));

    // Pointer wrap on ch1 with a bystander in ch5.
    @(negedge CLK);
    step(1, 5, 0, 5, W'('h55));
    step(1, 1, 0, 1, W'('h100));
    for (int i = 0; i < 6; i++) step(1, 1, 1, 1, W'('h101 + i));
    deq_idx = CL'(5);
    #1 chk("wrap.ch5", dot, W'('h55));
    @(negedge CLK);

    // Randomized traffic over a few channels so collisions are frequent.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), W'($urandom));
    end

    // Asynchronous reset mid-burst, checked before any clock edge.
    enq = 1'b1; enq_idx = CL'(2); din = W'('h77);
    #3 RST = 1'b0;
    #1;
    chk("arst.emp", W'(emp), {W{1'b0}} | {C{1'b1}});
    chk("arst.rdy", W'(rdy), {W{1'b0}} | {C{1'b1}});
    chk("arst.cnt", W'(cnt), W'(0));
    chk("arst.ovf", W'(ovf), W'(0));
    chk("arst.udf", W'(udf), W'(0));
    model_clear();
    @(negedge CLK);
    // Request held across the release edge must be ignored.
    RST = 1'b1; enq = 1'b1; enq_idx = CL'(2); deq = 1'b1; deq_idx = CL'(2);
    @(posedge CLK);
    @(negedge CLK);
    enq = 1'b0; deq = 1'b0;
    #1;
    chk("release.emp2", W'(emp[2]), W'(1));
    chk("release.udf", W'(udf), W'(0));
    @(negedge CLK);
    step(1, 2, 0, 2, W'('h33));
    step(0, 0, 0, 2, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_depth_fifo.md
MULTI_CHANNEL_DEPTH_FIFO -- requirements
Module: multi_channel_depth_fifo

Interface
REQ-001 SHALL have parameter C_LOG, default 5; channel count C = 1<<C_LOG.
REQ-002 SHALL have parameter FIFO_WIDTH, default 1024; data word width in bits.
REQ-003 SHALL have parameter D_LOG, default 2; per-channel depth D = 1<<D_LOG, D_LOG >= 1.
REQ-004 SHALL have parameter RDY_SLACK, default 1, range 1..D; free entries required before rdy asserts.
REQ-005 SHALL have port CLK, input, 1 bit; single clock, rising edge.
REQ-006 SHALL have port RST, input, 1 bit; reset, asynchronous, active-low.
REQ-007 SHALL have port enq, input, 1 bit; write request.
REQ-008 SHALL have port enq_idx, input, C_LOG bits; write channel.
REQ-009 SHALL have port deq, input, 1 bit; read request.
REQ-010 SHALL have port deq_idx, input, C_LOG bits; read channel.
REQ-011 SHALL have port din, input, FIFO_WIDTH bits; write data.
REQ-012 SHALL have port dot, output, FIFO_WIDTH bits; head word of channel deq_idx.
REQ-013 SHALL have port emp, output, C bits; emp[c] = channel c empty.
REQ-014 SHALL have port rdy, output, C bits; rdy[c] = channel c has >= RDY_SLACK free entries.
REQ-015 SHALL have port cnt, output, D_LOG+1 bits; occupancy of channel deq_idx.
REQ-016 SHALL have port ovf, output, 1 bit; sticky overflow error.
REQ-017 SHALL have port udf, output, 1 bit; sticky underflow error.

Function
REQ-018 SHALL keep, per channel, a D_LOG-bit write pointer, a D_LOG-bit read pointer and a (D_LOG+1)-bit count (0..D).
REQ-019 SHALL store data in one C*D-entry array addressed by {channel, pointer}.
REQ-020 SHALL be show-ahead: dot = array[{deq_idx, rptr[deq_idx]}], combinational from deq_idx and registered state; dot don't-care when emp[deq_idx]=1.
REQ-021 SHALL accept enq when count[enq_idx] < D: write din at wptr, wptr+1 modulo D, count+1, all at the next rising edge.
REQ-022 SHALL accept deq when count[deq_idx] > 0: rptr+1 modulo D, count-1.
REQ-023 SHALL derive emp[c] = (count[c]==0) and rdy[c] = (D-count[c] >= RDY_SLACK) from registered counts only; no combinational path from enq/deq.
REQ-024 SHALL, on accepted enq and deq to different channels in one cycle, update both independently.
REQ-025 SHALL, on enq and deq to the same non-empty channel, accept both; count unchanged, both pointers advance.
REQ-026 SHALL, on enq and deq to the same full channel, accept both (deq frees the slot); count stays D.
REQ-027 SHALL, on enq and deq to the same empty channel, accept enq only (no bypass), reject deq, set udf; count becomes 1.
REQ-028 SHALL drop enq to a full channel (other than REQ-026), leave state unchanged, set ovf.
REQ-029 SHALL ignore deq to an empty channel, leave state unchanged, set udf.
REQ-030 SHALL hold ovf/udf at 1 until reset.

Reset
REQ-031 SHALL, while RST=0, force all pointers and counts to 0, emp to all-ones, rdy to all-ones, cnt to 0, ovf and udf to 0, independent of CLK.
REQ-032 SHALL not reset the data array; dot undefined until the first write.
REQ-033 SHALL, on reset assertion mid-operation, discard all queued data; no request is accepted in the cycle RST deasserts.

Structure
REQ-034 SHALL take default parameter values (C_LOG, FIFO_WIDTH, D_LOG, RDY_SLACK) from the shared project constants header, not local literals.
REQ-035 SHALL instantiate sub-module mcfifo_chan_ctrl once per channel (pointers, count, emp, rdy, error pulses); top holds the array, read mux, sticky flags.

Verification
REQ-036 SHALL test: reset, then enq ch3 data 0xA,0xB,0xC,0xD (D=4) -> emp[3]=0, rdy[3]=0, cnt=4; 4 deq ch3 -> dot 0xA,0xB,0xC,0xD in order, emp[3]=1.
REQ-037 SHALL test: ch3 full, 5th enq 0xE -> dropped, ovf=1, count stays 4, ch3 head still 0xA.
REQ-038 SHALL test: ch0 empty, enq+deq ch0 same cycle data 0x5 -> udf=1, cnt(ch0)=1, dot=0x5.
REQ-039 SHALL test: ch7 full, enq 0x9 + deq ch7 same cycle -> both accepted, count 4, ovf=0, 0x9 emerges after 3 more deqs.
REQ-040 SHALL test: 6 enq/deq cycles forcing pointer wrap on ch1 -> FIFO order preserved, other channels unaffected.
REQ-041 SHALL test: RST=0 asynchronously mid-burst -> emp/rdy all ones, cnt=0, ovf=udf=0 without a clock edge.
